// File: rtl/router_pkg.sv
// Shared definitions for the credit-based router slice:
// flit type encodings, field offsets and framing states.
package router_pkg;

    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    localparam int TYPE_LSB = 0;
    localparam int ADDR_LSB = 2;

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } frame_state_t;

endpackage

// File: rtl/router_slice_fifo.sv
// Synchronous FIFO with wrap-bit pointers. Push while full is only
// legal when a pop happens on the same edge.
module router_slice_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/router_slice_credit.sv
// Buffered router slice: input FIFO, downstream credit counter,
// framing checker, registered output stage and sticky ERROR.
module router_slice_credit
    import router_pkg::*;
#(
    parameter int FLIT_W  = 68,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ROUTER_ADDRESS,
    input  logic              VALID_IN_IP,
    input  logic [FLIT_W-1:0] CHANNEL_IN_IP,
    input  logic              CREDIT_IN_OP,
    output logic              VALID_OUT_OP,
    output logic [FLIT_W-1:0] CHANNEL_OUT_OP,
    output logic              CREDIT_OUT_IP,
    output logic              LOOPBACK_OUT,
    output logic              ERROR
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    logic              fifo_full;
    logic              fifo_empty;
    logic [FLIT_W-1:0] head_flit;
    logic              push;
    logic              pop;
    logic              overflow;
    logic [1:0]        in_type;
    logic [1:0]        out_type;
    logic              out_is_head;

    logic [CW-1:0]     credits;
    logic [CW-1:0]     credits_next;
    logic              credit_err;

    frame_state_t      state;
    frame_state_t      state_next;
    logic              frame_err;

    assign pop      = !fifo_empty && (credits != '0);
    // A full FIFO still accepts when the same edge frees a slot.
    assign push     = VALID_IN_IP && (!fifo_full || pop);
    assign overflow = VALID_IN_IP && fifo_full && !pop;
    assign in_type  = CHANNEL_IN_IP[TYPE_LSB +: 2];
    assign out_type = head_flit[TYPE_LSB +: 2];
    assign out_is_head = (out_type == FLIT_HEAD) ||
                         (out_type == FLIT_SINGLE);

    router_slice_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .wdata (CHANNEL_IN_IP),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (head_flit)
    );

    always_comb begin
        credits_next = credits;
        credit_err   = 1'b0;
        if (CREDIT_IN_OP && !pop) begin
            if (credits == CRED_MAX) credit_err = 1'b1;
            else credits_next = credits + 1'b1;
        end else if (pop && !CREDIT_IN_OP) begin
            credits_next = credits - 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        frame_err  = 1'b0;
        if (push) begin
            unique case (state)
                ST_IDLE: begin
                    if (in_type == FLIT_HEAD) state_next = ST_IN_PKT;
                    else if (in_type != FLIT_SINGLE) frame_err = 1'b1;
                end
                ST_IN_PKT: begin
                    if (in_type == FLIT_TAIL) begin
                        state_next = ST_IDLE;
                    end else if (in_type == FLIT_HEAD) begin
                        frame_err = 1'b1;
                    end else if (in_type == FLIT_SINGLE) begin
                        frame_err  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            credits        <= CRED_MAX;
            VALID_OUT_OP   <= 1'b0;
            CHANNEL_OUT_OP <= '0;
            CREDIT_OUT_IP  <= 1'b0;
            LOOPBACK_OUT   <= 1'b0;
            ERROR          <= 1'b0;
        end else begin
            state         <= state_next;
            credits       <= credits_next;
            VALID_OUT_OP  <= pop;
            CREDIT_OUT_IP <= pop;
            LOOPBACK_OUT  <= pop && out_is_head &&
                (head_flit[ADDR_LSB +: ADDR_W] == ROUTER_ADDRESS);
            if (pop) CHANNEL_OUT_OP <= head_flit;
            if (overflow || frame_err || credit_err) ERROR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_router_slice_credit.sv
// Scoreboard bench for router_slice_credit: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_router_slice_credit;

    localparam int FLIT_W  = 68;
    localparam int DEPTH   = 4;
    localparam int CREDITS = 4;
    localparam int ADDR_W  = 4;
    localparam logic [ADDR_W-1:0] MY_ADDR = 4'd5;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] router_address;
    logic              valid_in;
    logic [FLIT_W-1:0] chan_in;
    logic              credit_in;
    logic              valid_out;
    logic [FLIT_W-1:0] chan_out;
    logic              credit_out;
    logic              loopback;
    logic              error;

    router_slice_credit #(
        .FLIT_W  (FLIT_W),
        .DEPTH   (DEPTH),
        .CREDITS (CREDITS),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .ROUTER_ADDRESS (router_address),
        .VALID_IN_IP    (valid_in),
        .CHANNEL_IN_IP  (chan_in),
        .CREDIT_IN_OP   (credit_in),
        .VALID_OUT_OP   (valid_out),
        .CHANNEL_OUT_OP (chan_out),
        .CREDIT_OUT_IP  (credit_out),
        .LOOPBACK_OUT   (loopback),
        .ERROR          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [FLIT_W-1:0] flit;
        bit                lb;
        int                e;
    } exp_t;

    exp_t              sb[$];
    logic [FLIT_W-1:0] mq[$];
    int                m_cred;
    bit                m_err;
    bit                m_inpkt;
    int                edge_n = 0;
    int                n_cmp  = 0;
    int                n_bad  = 0;

    task automatic chk(string nm, logic [FLIT_W-1:0] act,
                       logic [FLIT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)",
                     nm, act, exp, edge_n);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk(logic [1:0] t,
                                             logic [ADDR_W-1:0] a);
        logic [FLIT_W-1:0] f;
        f = FLIT_W'({$urandom, $urandom, $urandom});
        f[1:0] = t;
        f[2 +: ADDR_W] = a;
        return f;
    endfunction

    function automatic bit lb_of(logic [FLIT_W-1:0] f);
        return (f[1:0] == 2'b01 || f[1:0] == 2'b11) &&
               (f[2 +: ADDR_W] == MY_ADDR);
    endfunction

    // Packet grammar: a packet is HEAD BODY* TAIL, or a lone SINGLE.
    task automatic frame(logic [1:0] t);
        if (!m_inpkt) begin
            if (t == 2'b01) m_inpkt = 1;
            else if (t != 2'b11) m_err = 1;
        end else begin
            if (t == 2'b10) m_inpkt = 0;
            else if (t == 2'b01) m_err = 1;
            else if (t == 2'b11) begin m_err = 1; m_inpkt = 0; end
        end
    endtask

    task automatic cyc(bit v, logic [FLIT_W-1:0] f, bit c);
        bit pop;
        @(negedge clk);
        valid_in  = v;
        chan_in   = f;
        credit_in = c;
        pop = (mq.size() > 0) && (m_cred > 0);
        if (pop) sb.push_back('{mq[0], lb_of(mq[0]), edge_n + 1});
        if (pop) void'(mq.pop_front());
        if (v) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(f);
                frame(f[1:0]);
            end else begin
                m_err = 1;
            end
        end
        if (c && !pop) begin
            if (m_cred == CREDITS) m_err = 1;
            else m_cred++;
        end else if (pop && !c) begin
            m_cred--;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_in  = 0;
        credit_in = 0;
        rst_n     = 0;
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_chan", chan_out, 0);
        chk("rst_credit_out", credit_out, 0);
        chk("rst_loopback", loopback, 0);
        chk("rst_error", error, 0);
        mq.delete();
        sb.delete();
        m_cred  = CREDITS;
        m_err   = 0;
        m_inpkt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin : monitor
        exp_t x;
        bit   ev;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            ev = (sb.size() > 0) && (sb[0].e == edge_n);
            chk("valid_out", valid_out, ev);
            chk("credit_out", credit_out, ev);
            if (ev) begin
                x = sb.pop_front();
                chk("chan_out", chan_out, x.flit);
                chk("loopback", loopback, x.lb);
            end else begin
                chk("loopback_idle", loopback, 0);
            end
            chk("error", error, m_err);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n          = 1;
        valid_in       = 0;
        chan_in        = '0;
        credit_in      = 0;
        router_address = MY_ADDR;
        m_cred         = CREDITS;
        #1 rst_n = 0;
        do_reset();

        // HEAD/BODY/TAIL stream, then one credit left: only 1 of 2 goes.
        cyc(1, mk(2'b01, 4'd3), 0);
        cyc(1, mk(2'b00, 4'd0), 0);
        cyc(1, mk(2'b10, 4'd0), 0);
        idle(4);
        cyc(1, mk(2'b11, 4'd2), 0);
        cyc(1, mk(2'b11, 4'd2), 0);
        idle(4);

        // Credit starvation, then two returned credits.
        do_reset();
        cyc(1, mk(2'b01, 4'd1), 0);
        for (int i = 0; i < 4; i++) cyc(1, mk(2'b00, 4'd0), 0);
        cyc(1, mk(2'b10, 4'd0), 0);
        idle(4);
        cyc(0, '0, 1);
        idle(3);
        cyc(0, '0, 1);
        idle(4);

        // Overflow with zero credits: DEPTH+1 flits.
        cyc(1, mk(2'b01, 4'd1), 0);
        for (int i = 0; i < DEPTH - 1; i++) cyc(1, mk(2'b00, 4'd0), 0);
        cyc(1, mk(2'b10, 4'd0), 0);
        idle(4);
        cyc(0, '0, 1);
        idle(4);

        // Framing: BODY from IDLE, then HEAD, HEAD.
        do_reset();
        cyc(1, mk(2'b00, 4'd5), 0);
        cyc(1, mk(2'b01, 4'd5), 0);
        cyc(1, mk(2'b01, 4'd7), 0);
        idle(4);

        // Loopback and credit overflow.
        do_reset();
        cyc(1, mk(2'b11, 4'd5), 0);
        idle(3);
        cyc(0, '0, 1);
        idle(2);
        cyc(0, '0, 1);
        idle(3);

        // Reset mid-packet with HEAD and BODY buffered.
        do_reset();
        for (int i = 0; i < CREDITS; i++) cyc(1, mk(2'b11, 4'd9), 0);
        idle(3);
        cyc(1, mk(2'b01, 4'd4), 0);
        cyc(1, mk(2'b00, 4'd0), 0);
        idle(1);
        do_reset();
        idle(3);
        cyc(1, mk(2'b01, 4'd5), 0);
        cyc(1, mk(2'b10, 4'd0), 0);
        idle(4);

        // Randomized traffic with periodic resets.
        for (int r = 0; r < 5; r++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                cyc(($urandom % 4) != 0,
                    mk(2'($urandom), ADDR_W'($urandom_range(0, 7))),
                    ($urandom % 3) == 0);
            end
            idle(2);
        end

        idle(8);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/router_slice_credit.md
# router_slice_credit

Parametrised, buffered successor to the single-register NoC router slice. It accepts flits from the upstream IP channel into an input FIFO and forwards them to the output port under credit-based flow control. It returns credits upstream and checks packet framing (head/body/tail order). It sits between a tile's network interface and the first router port, and is the building block for multi-slice router pipelines.

## Interface
- FLIT_W, default 68: flit width. Bits [0:1] carry the flit type; bits [2:2+ADDR_W-1] of a head flit carry the destination address.
- DEPTH, default 4: input FIFO depth in flits; power of two, ≥2. Equals the number of credits the upstream holds after reset.
- CREDITS, default 4: downstream buffer depth; sets the initial and maximum credit count.
- ADDR_W, default 4: router address width.
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset. Assertion clears state immediately; deassertion is synchronous to clk.
- ROUTER_ADDRESS, input, ADDR_W: this slice's address, static after reset.
- VALID_IN_IP, input, 1: CHANNEL_IN_IP carries a flit this cycle.
- CHANNEL_IN_IP, input, FLIT_W: incoming flit.
- CREDIT_IN_OP, input, 1: one-cycle pulse; the downstream freed one buffer slot.
- VALID_OUT_OP, output, 1: CHANNEL_OUT_OP carries a flit this cycle.
- CHANNEL_OUT_OP, output, FLIT_W: outgoing flit, registered.
- CREDIT_OUT_IP, output, 1: one-cycle pulse per flit dequeued; returned to upstream.
- LOOPBACK_OUT, output, 1: registered; high with VALID_OUT_OP when the forwarded head's address equals ROUTER_ADDRESS.
- ERROR, output, 1: sticky protocol-error flag; cleared only by reset.

## Operation
- Flit types in [0:1]: 01 HEAD, 00 BODY, 10 TAIL, 11 SINGLE (head and tail).
- Enqueue: VALID_IN_IP=1 writes the flit into the FIFO at the clock edge.
  - If the FIFO is full and no pop occurs that cycle, the flit is dropped and ERROR is set.
  - If the FIFO is full and a pop occurs the same cycle, the write succeeds.
- Credit counter: width clog2(CREDITS+1); reset value CREDITS.
- Dequeue condition: FIFO non-empty and credit counter >0. On a dequeue edge:
  - the head flit is registered onto CHANNEL_OUT_OP with VALID_OUT_OP=1;
  - CREDIT_OUT_IP is pulsed;
  - the credit counter is decremented.
- When no dequeue occurs, VALID_OUT_OP=0 and CHANNEL_OUT_OP holds its last value.
- CREDIT_IN_OP increments the credit counter.
  - Increment and decrement in the same cycle leave the count unchanged.
  - An increment at count==CREDITS with no decrement is ignored and sets ERROR.
- Framing FSM, checked on the input side for each accepted flit. States IDLE and IN_PKT; reset state IDLE.
  - IDLE: HEAD → IN_PKT; SINGLE → IDLE; BODY or TAIL → ERROR set, stay IDLE.
  - IN_PKT: BODY → IN_PKT; TAIL → IDLE; HEAD or SINGLE → ERROR set, move to IN_PKT for HEAD or IDLE for SINGLE.
  - Framing-error flits are still enqueued and forwarded; the slice never drops flits except on overflow.
- LOOPBACK_OUT is evaluated on dequeue for HEAD and SINGLE flits; it is 0 for all other flits.
- Reset values: VALID_OUT_OP=0, CHANNEL_OUT_OP=0, CREDIT_OUT_IP=0, LOOPBACK_OUT=0, ERROR=0, FIFO empty, credits=CREDITS, FSM=IDLE.
- Reset asserted mid-packet discards all FIFO contents and in-flight credits.

## Timing
- Minimum latency is 2 cycles: a flit written at edge k into an empty FIFO with credits >0 is dequeued at edge k+1, so VALID_OUT_OP is high in the cycle after edge k+1.
- No combinational path from any input to any output.
- Sustained throughput is 1 flit/cycle when credits never reach 0.
- A credit received at edge k enables a dequeue at edge k+1 at the earliest.
- CREDIT_OUT_IP pulses in the same cycle as the corresponding VALID_OUT_OP.

## Structure
- Shared package router_pkg holds:
  - flit-type constants (FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE);
  - field offsets (TYPE_LSB, ADDR_LSB);
  - the framing-FSM state typedef.
- Sub-module router_slice_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with push, pop, full, empty and data outputs. Pointers are clog2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty on pointer wrap-around.
- The top level contains the credit counter, framing FSM, output register and ERROR logic.

## Test plan
- Reset then stream: send HEAD(addr 3), BODY, TAIL on consecutive cycles with CREDITS=4.
  - Required: VALID_OUT_OP on 3 consecutive cycles starting 2 cycles after the first input.
  - Required: 3 CREDIT_OUT_IP pulses, credit count 1, ERROR=0.
- Credit starvation: send 6 flits without any CREDIT_IN_OP.
  - Required: exactly 4 flits forwarded and 2 held in the FIFO.
  - Then pulse CREDIT_IN_OP twice: the remaining 2 flits are forwarded, one per credit, in order.
- Overflow: hold credits at 0 and send DEPTH+1 flits.
  - Required: the last flit is dropped and ERROR rises the cycle after its edge.
  - Required: ERROR stays 1 until reset.
- Framing: send BODY while in IDLE, then HEAD, HEAD.
  - Required: ERROR set after the first flit; all 3 flits are still forwarded.
- Loopback and credit overflow: with ROUTER_ADDRESS=5, send SINGLE(addr 5).
  - Required: LOOPBACK_OUT=1 with VALID_OUT_OP.
  - Then, once credits are back at 4, pulse CREDIT_IN_OP: ERROR=1 and the count stays 4.
- Reset mid-packet: assert reset after HEAD and one BODY are buffered.
  - Required: all outputs 0 immediately and FIFO empty.
  - Required: after release, a fresh HEAD/TAIL forwards with no ERROR.
